controller_sequencer: RTL
=========================

// Module: controller_sequencer
// PURPOSE
// Control/sequencer for the 8-bit CPU. A 6-state ring counter (T1..T6) issues
// the control word for fetch (T1-T3) and execute (T4-T6) of the opcode held in
// the instruction register, drives ir's li/ei/t0, and stops the machine on HLT.
// Supports free-run and single-step operation.
// PARAMETERS
// OPC_W   4     opcode width (instr_out_h of ir)
// OP_LDA  4'h0  load A from memory;  OP_ADD 4'h1;  OP_SUB 4'h2
// OP_OUT  4'hE  A -> output register; OP_HLT 4'hF
// PORTS
// clk      in   1      system clock, rising edge
// reset    in   1      asynchronous, active-high; forces T1, clears halt
// run      in   1      1 = free-run; 0 = single-step via step
// step     in   1      one-clk pulse; advances one T-state when run=0
// opcode   in   OPC_W  from ir instr_out_h
// t_state  out  6      one-hot ring (bit0=T1 .. bit5=T6)
// t0       out  1      high in T1 (feeds ir t0)
// cp ep lm ce li ei la ea su eu lb lo  out 1 each, active-high control word
// lp       out  1      load PC from bus (only with macro, else tied 0)
// hlt      out  1      machine halted; gates clock enable to datapath
// BEHAVIOUR
// - Reset (async): t_state=6'b000001, hlt=0; control word = T1 decode (ep,lm=1).
// - State advances T1->T2->..->T6->T1 on rising clk when adv=1,
//   adv = ~hlt & (run | step). run dominates if both high; step held high
//   for N clocks in step mode advances N states (pulse width is bench's job).
// - Control word is combinational from t_state and registered-as-given opcode;
//   exactly one state bit high at all times; all unlisted signals 0.
//   T1: ep,lm   T2: cp   T3: ce,li
//   LDA T4: ei,lm  T5: ce,la  T6: -
//   ADD T4: ei,lm  T5: ce,lb  T6: eu,la
//   SUB T4: ei,lm  T5: ce,lb  T6: su,eu,la
//   OUT T4: ea,lo  T5: -      T6: -
//   HLT T4: hlt set on the rising edge ending T4 (sticky); while hlt=1 the
//       ring freezes at T5 and the whole control word is forced 0.
//   Any other opcode: T4-T6 all 0 (NOP); ring still runs full 6 states.
// - Latency: one instruction = 6 advancing clocks; no early termination.
// - opcode only sampled in T4-T6; value during T1-T3 is don't-care.
// - Reset mid-instruction: returns to T1 immediately, in-flight instr dropped.
// - Only reset clears hlt; run/step ignored while halted.
// - Illegal ring state (not one-hot) recovers to T1 on next adv.
// CONFIGURATION
// CTRL_JMP_EN defined: opcode 4'h3 = JMP; T4: ei,lp; T5,T6: -. lp port active.
// CTRL_JMP_EN undefined: 4'h3 decodes as NOP; lp tied 0.
// TESTING
// 1 reset=1 async mid-clock -> t_state=000001, t0=1, ep=lm=1, hlt=0 at once.
// 2 run=1, opcode=4'h0 -> T1..T6 words: {ep,lm},{cp},{ce,li},{ei,lm},{ce,la},{0}; back to T1.
// 3 run=1, opcode=4'h2 -> T6 has su=eu=la=1, all others 0; opcode=4'h7 -> T4-T6 all 0.
// 4 opcode=4'hF -> after T4 edge hlt=1, t_state=T5 stays 20 clks, word=0; reset clears.
// 5 run=0, three 1-clk step pulses spaced 5 clks -> ring moves T1->T4 only on pulses.
// 6 CTRL_JMP_EN, opcode=4'h3 -> T4 ei=lp=1; without macro lp=0 throughout; reset in T5 -> T1.

Source files
------------

// File: rtl/controller_sequencer.sv
// Control sequencer for the 8-bit CPU: six-state one-hot ring issuing fetch/execute control words.
// Optional JMP decode (opcode 4'h3, drives lp) is enabled by defining CTRL_JMP_EN.
module controller_sequencer #(
  parameter int               OPC_W  = 4,
  parameter logic [OPC_W-1:0] OP_LDA = 4'h0,
  parameter logic [OPC_W-1:0] OP_ADD = 4'h1,
  parameter logic [OPC_W-1:0] OP_SUB = 4'h2,
  parameter logic [OPC_W-1:0] OP_OUT = 4'hE,
  parameter logic [OPC_W-1:0] OP_HLT = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [OPC_W-1:0] opcode,
  output logic [5:0]       t_state,
  output logic             t0,
  output logic             cp,
  output logic             ep,
  output logic             lm,
  output logic             ce,
  output logic             li,
  output logic             ei,
  output logic             la,
  output logic             ea,
  output logic             su,
  output logic             eu,
  output logic             lb,
  output logic             lo,
  output logic             lp,
  output logic             hlt
);

  localparam logic [5:0] ST_T1 = 6'b000001;
  localparam logic [5:0] ST_T2 = 6'b000010;
  localparam logic [5:0] ST_T3 = 6'b000100;
  localparam logic [5:0] ST_T4 = 6'b001000;
  localparam logic [5:0] ST_T5 = 6'b010000;
  localparam logic [5:0] ST_T6 = 6'b100000;

  // Control word bit masks, ordered {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
  localparam logic [11:0] W_CP = 12'b1000_0000_0000;
  localparam logic [11:0] W_EP = 12'b0100_0000_0000;
  localparam logic [11:0] W_LM = 12'b0010_0000_0000;
  localparam logic [11:0] W_CE = 12'b0001_0000_0000;
  localparam logic [11:0] W_LI = 12'b0000_1000_0000;
  localparam logic [11:0] W_EI = 12'b0000_0100_0000;
  localparam logic [11:0] W_LA = 12'b0000_0010_0000;
  localparam logic [11:0] W_EA = 12'b0000_0001_0000;
  localparam logic [11:0] W_SU = 12'b0000_0000_1000;
  localparam logic [11:0] W_EU = 12'b0000_0000_0100;
  localparam logic [11:0] W_LB = 12'b0000_0000_0010;
  localparam logic [11:0] W_LO = 12'b0000_0000_0001;

`ifdef CTRL_JMP_EN
  localparam logic [OPC_W-1:0] OP_JMP = 4'h3;
  logic lp_s;
`endif

  logic [5:0]  t_state_r;
  logic        hlt_r;
  logic        adv_s;
  logic [11:0] ctrl_s;

  function automatic logic is_onehot(input logic [5:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 6; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return (cnt == 3'd1);
  endfunction

  assign adv_s = ~hlt_r & (run | step);

  // Ring advance; HLT in T4 parks the ring at T5 with the sticky halt flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_state_r <= ST_T1;
      hlt_r     <= 1'b0;
    end else if (adv_s) begin
      if ((t_state_r == ST_T4) && (opcode == OP_HLT)) begin
        t_state_r <= ST_T5;
        hlt_r     <= 1'b1;
      end else if (is_onehot(t_state_r)) begin
        t_state_r <= {t_state_r[4:0], t_state_r[5]};
      end else begin
        t_state_r <= ST_T1;
      end
    end else begin
      t_state_r <= t_state_r;
      hlt_r     <= hlt_r;
    end
  end

  // Control word decode from ring position and opcode
  always_comb begin
    ctrl_s = 12'd0;
`ifdef CTRL_JMP_EN
    lp_s = 1'b0;
`endif
    if (hlt_r) begin
      ctrl_s = 12'd0;
    end else begin
      case (t_state_r)
        ST_T1: ctrl_s = W_EP | W_LM;
        ST_T2: ctrl_s = W_CP;
        ST_T3: ctrl_s = W_CE | W_LI;
        ST_T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: ctrl_s = W_EI | W_LM;
            OP_OUT:                 ctrl_s = W_EA | W_LO;
`ifdef CTRL_JMP_EN
            OP_JMP: begin
              ctrl_s = W_EI;
              lp_s   = 1'b1;
            end
`endif
            default:                ctrl_s = 12'd0;
          endcase
        end
        ST_T5: begin
          case (opcode)
            OP_LDA:         ctrl_s = W_CE | W_LA;
            OP_ADD, OP_SUB: ctrl_s = W_CE | W_LB;
            default:        ctrl_s = 12'd0;
          endcase
        end
        ST_T6: begin
          case (opcode)
            OP_ADD:  ctrl_s = W_EU | W_LA;
            OP_SUB:  ctrl_s = W_SU | W_EU | W_LA;
            default: ctrl_s = 12'd0;
          endcase
        end
        default: ctrl_s = 12'd0;
      endcase
    end
  end

  assign {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = ctrl_s;
  assign t_state = t_state_r;
  assign t0      = t_state_r[0];
  assign hlt     = hlt_r;

`ifdef CTRL_JMP_EN
  assign lp = lp_s;
`else
  assign lp = 1'b0;
`endif

endmodule
